neuron_mac_seq: RTL
===================

Name: neuron_mac_seq

Overview:
- Sequencer and MAC stage directly downstream of one neuron's weight BRAM (28 x 16-bit, 5-bit address, read on falling CLK edge, DO registered).
- Walks addresses 0..N_INPUTS-1 on a shared address bus that drives both the weight BRAM and the matching input-activation BRAM.
- Multiplies each weight/activation pair and accumulates the products, then adds a bias.
- Applies optional ReLU and saturation, and presents a single Q8.8 neuron output with a one-cycle DONE pulse.

Parameters:
- N_INPUTS, 28, number of weight/activation pairs per neuron.
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= N_INPUTS.
- DATA_W, 16, signed fixed-point width of weights, activations, bias and result (Q8.8).
- FRAC_BITS, 8, fractional bits of the DATA_W format.
- ACC_W, 40, signed accumulator width.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass signed result.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin one neuron evaluation; sampled only in IDLE.
- BIAS  in  DATA_W  signed Q8.8 bias; captured on the START edge.
- ADDR  out  ADDR_W  registered address to the weight and activation BRAMs.
- EN  out  1  registered BRAM enable.
- WE  out  1  tied 0; this block never writes the BRAMs.
- W_DO  in  DATA_W  weight data returned by the weight BRAM.
- X_DO  in  DATA_W  activation data returned by the activation BRAM.
- BUSY  out  1  high from the START edge until the DONE cycle, exclusive.
- RESULT  out  DATA_W  signed Q8.8 neuron output; holds its value until the next DONE.
- DONE  out  1  one-cycle pulse when RESULT is updated.

Behaviour:
- Reset values: ADDR=0, EN=0, WE=0, BUSY=0, DONE=0, RESULT=0, accumulator=0, state=IDLE. Reset takes priority over every other event.
- Reset asserted mid-run aborts the evaluation: no DONE is issued and RESULT keeps its reset value of 0.
- States are IDLE, RUN, FINAL.
- IDLE:
  - On START=1 at edge 0: capture BIAS, clear the accumulator, set ADDR=0, EN=1, BUSY=1, and go to RUN.
- RUN, at edge k for k = 1..N_INPUTS:
  - Do acc += sext(W_DO) * sext(X_DO). The operands are the BRAM data for address k-1, returned on the falling edge between edges k-1 and k.
  - For k < N_INPUTS: ADDR=k.
  - At k = N_INPUTS: EN=0, ADDR=0, go to FINAL.
- FINAL, at edge N_INPUTS+1:
  - sum = (acc + (sext(BIAS) << FRAC_BITS)) >>> FRAC_BITS. The shift is arithmetic and truncates toward negative infinity.
  - Saturate sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If RELU_EN=1, force negative values to 0.
  - Register the result into RESULT, pulse DONE=1 for one cycle, set BUSY=0, and go to IDLE.
- Timing:
  - EN is high for exactly N_INPUTS cycles.
  - ADDR steps 0,1,...,N_INPUTS-1, one per cycle, with no gaps and no repeats.
  - DONE asserts N_INPUTS+1 cycles after the START edge (29 with defaults).
- START while BUSY=1 is ignored and has no effect on the running evaluation.
- START sampled in the same cycle DONE is high is accepted, because the state is already IDLE. Back-to-back evaluations therefore have a period of N_INPUTS+2 cycles.
- Products are full 2*DATA_W signed and sign-extended to ACC_W. With the defaults the accumulator cannot overflow, so no internal wrap is permitted.
- WE is constant 0 in every state.

Test Plan:
- All W=0x0100, all X=0x0100, BIAS=0, START one cycle -> ADDR 0..27 with EN high for 28 cycles, WE=0 throughout, DONE 29 cycles after START, RESULT=0x1C00 (28.0).
- W=0x0080, X=0xFF00, BIAS=0x0100 -> RELU_EN=1 gives RESULT=0x0000; RELU_EN=0 gives RESULT=0xF300 (-13.0).
- W=0x7FFF, X=0x7FFF, BIAS=0x7FFF -> RESULT=0x7FFF (positive saturation); W=0x8000, X=0x7FFF, RELU_EN=0 -> RESULT=0x8000 (negative saturation).
- Pulse START again at cycles 5 and 20 of a run -> ignored, exactly one DONE, RESULT unchanged from the clean-run value; START in the DONE cycle -> second run starts immediately and gives an identical RESULT.
- Assert RST at cycle 10 of a run -> next edge: EN=0, ADDR=0, BUSY=0, no DONE; then a fresh START with the first test's data -> RESULT=0x1C00.
- Alternating W=+0x0100/-0x0100, X=0x0100, BIAS=0xFF80, RELU_EN=0 -> RESULT=0xFF80 (-0.5), confirming bias alignment and sign handling.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Address sequencer and multiply-accumulate stage for one neuron: walks the weight/activation
// BRAMs, accumulates the products, adds the bias, then saturates (and optionally ReLUs) to Q8.8.
module neuron_mac_seq #(
    parameter int N_INPUTS  = 28,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic signed [DATA_W-1:0] BIAS,
    output logic [ADDR_W-1:0]        ADDR,
    output logic                     EN,
    output logic                     WE,
    input  logic signed [DATA_W-1:0] W_DO,
    input  logic signed [DATA_W-1:0] X_DO,
    output logic                     BUSY,
    output logic signed [DATA_W-1:0] RESULT,
    output logic                     DONE
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINAL
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W:0] SAT_MAX =
        $signed({{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN =
        $signed({{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}});

    state_t                     state_p0, state_nxt;
    logic [ADDR_W-1:0]          addr_p0, addr_nxt;
    logic                       en_p0, en_nxt;
    logic                       busy_p0, busy_nxt;
    logic                       done_p0, done_nxt;
    logic signed [ACC_W-1:0]    acc_p0, acc_nxt;
    logic signed [DATA_W-1:0]   bias_p0, bias_nxt;
    logic signed [DATA_W-1:0]   result_p0, result_nxt;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_al;
    logic signed [ACC_W:0]      sum_full;
    logic signed [ACC_W:0]      sum_sh;

    function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_q(input logic signed [DATA_W-1:0] v);
        if (RELU_EN && v[DATA_W-1]) begin
            return '0;
        end
        return v;
    endfunction

    // BRAM data arrives on the falling edge, so it is consumed combinationally here.
    assign prod     = W_DO * X_DO;
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_al  = {{(ACC_W - DATA_W - FRAC_BITS){bias_p0[DATA_W-1]}}, bias_p0, {FRAC_BITS{1'b0}}};
    assign sum_full = {acc_p0[ACC_W-1], acc_p0} + {bias_al[ACC_W-1], bias_al};
    assign sum_sh   = sum_full >>> FRAC_BITS;

    always_comb begin
        state_nxt  = state_p0;
        addr_nxt   = addr_p0;
        en_nxt     = en_p0;
        busy_nxt   = busy_p0;
        done_nxt   = 1'b0;
        acc_nxt    = acc_p0;
        bias_nxt   = bias_p0;
        result_nxt = result_p0;
        case (state_p0)
            IDLE: begin
                if (START) begin
                    bias_nxt  = BIAS;
                    acc_nxt   = '0;
                    addr_nxt  = '0;
                    en_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                acc_nxt = acc_p0 + prod_ext;
                if (addr_p0 == LAST_ADDR) begin
                    en_nxt    = 1'b0;
                    addr_nxt  = '0;
                    state_nxt = FINAL;
                end else begin
                    addr_nxt = addr_p0 + ADDR_W'(1);
                end
            end
            FINAL: begin
                result_nxt = relu_q(sat_q(sum_sh));
                done_nxt   = 1'b1;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: all architectural state; reset clears data as well so an abort leaves RESULT at 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p0  <= IDLE;
            addr_p0   <= '0;
            en_p0     <= 1'b0;
            busy_p0   <= 1'b0;
            done_p0   <= 1'b0;
            acc_p0    <= '0;
            bias_p0   <= '0;
            result_p0 <= '0;
        end else begin
            state_p0  <= state_nxt;
            addr_p0   <= addr_nxt;
            en_p0     <= en_nxt;
            busy_p0   <= busy_nxt;
            done_p0   <= done_nxt;
            acc_p0    <= acc_nxt;
            bias_p0   <= bias_nxt;
            result_p0 <= result_nxt;
        end
    end

    assign ADDR   = addr_p0;
    assign EN     = en_p0;
    assign WE     = 1'b0;
    assign BUSY   = busy_p0;
    assign DONE   = done_p0;
    assign RESULT = result_p0;

endmodule
